// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the quotient value reported on divide-by-zero.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Sized for the widest supported operand; users slice off the low WIDTH bits.
  localparam int unsigned DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/iter_divider_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage and
// the divider.
interface iter_divider_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {r_i, q_msb_i};
  // The borrow lands in the MSB of the WIDTH+1-bit difference.
  assign trial   = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~trial[WIDTH];
  // A restored remainder is always below the divisor, so WIDTH bits suffice.
  assign r_o     = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/iter_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock, with
// results held stable until the next accepted start completes.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  iter_divider_if.slave bus
);
  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q_bit;
  logic [WIDTH-1:0] q_shifted;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .r_o       (step_r),
    .q_bit_o   (step_q_bit)
  );

  assign q_shifted = {q_q[WIDTH-2:0], step_q_bit};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    r_d       = r_q;
    q_d       = q_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide-by-zero completes immediately without iterating.
            state_d = DIV_DONE;
            quot_d  = DIV_ZERO_QUOT[WIDTH-1:0];
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d   = DIV_RUN;
            q_d       = bus.dividend;
            r_d       = '0;
            count_d   = '0;
            divisor_d = bus.divisor;
            dbz_d     = 1'b0;
          end
        end
      end
      DIV_RUN: begin
        r_d     = step_r;
        q_d     = q_shifted;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_DONE;
          quot_d  = q_shifted;
          rem_d   = step_r;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      r_q       <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      r_q       <= r_d;
      q_q       <= q_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != DIV_IDLE);
  assign bus.done        = (state_q == DIV_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Unsigned sequential restoring divider producing quotient and remainder, one quotient bit per clock.
- Complements the ALU's carry-lookahead adder path by supplying the inverse arithmetic operation.
- Sits beside the ALU in the EX stage; the pipeline stalls on busy.
- Start/busy/done handshake; results held stable until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  registered result.
- remainder  output  WIDTH  registered result.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; internal regs=0.
- States: IDLE, RUN, DONE; registered, no combinational output paths from start.
- IDLE + start=1 at edge N, divisor≠0:
  - Capture operands; Q=dividend; partial remainder R (WIDTH+1 bits)=0; count=0; div_by_zero cleared.
  - Next state RUN.
- IDLE + start=1 at edge N, divisor=0:
  - Next state DONE.
  - quotient={WIDTH{1}}; remainder=dividend; div_by_zero=1.
  - done visible in the cycle after edge N.
- RUN, each edge:
  - T={R[WIDTH-1:0],Q[WIDTH-1]} − {0,divisor} (WIDTH+1 bits).
  - If T non-negative (MSB=0): R=T, shift Q left with LSB=1.
  - Else: R={R[WIDTH-1:0],Q[WIDTH-1]}, shift Q left with LSB=0.
  - count++.
- RUN exit: on the edge where count==WIDTH−1 is processed, next state DONE, and quotient/remainder load from the final Q/R.
  - Latency: done high during the cycle following edge N+WIDTH (16 RUN edges for WIDTH=16).
- DONE: done=1, busy=1 for exactly one cycle; next state IDLE unconditionally.
- start while busy (RUN or DONE): ignored, no queuing. Operands may change freely while busy.
- quotient, remainder and div_by_zero hold their values until the next accepted start loads new results at its completion. Outputs are not cleared at start.
- Reset mid-RUN: immediately returns to IDLE with all outputs zeroed; no done pulse.
- Widths:
  - Subtractor is WIDTH+1 bits; the borrow is its MSB.
  - No overflow is possible for unsigned operands; quotient ≤ dividend.
- dividend=0, divisor≠0: runs the full WIDTH cycles; q=0, r=0.

Decomposition:
- Shared package (div_pkg):
  - State encoding constants DIV_IDLE=2'b00, DIV_RUN=2'b01, DIV_DONE=2'b10.
  - DIV_ZERO_QUOT constant (all ones).
- One sub-module: div_step, combinational.
  - Inputs: R, Q MSB, divisor.
  - Outputs: next R, quotient bit.
  - Wraps the WIDTH+1-bit subtract so the adder structure can later be swapped to a lookahead implementation.
- Top holds FSM, counter and result registers.

Test Plan:
- 100/7 with start at edge N → busy from N+1; done in cycle after N+16; quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF/1 → quotient=0xFFFF, remainder=0. Then 5/9 back-to-back (start in the cycle after done) → quotient=0, remainder=5.
- 1234/0 → done one cycle after the start edge; quotient=0xFFFF, remainder=1234, div_by_zero=1. A following 10/3 → div_by_zero=0, q=3, r=1.
- start pulsed with 50/5 at cycle 5 of a running 100/7 → ignored; result still 14 r2; exactly one done pulse; no second operation.
- rst_n low at RUN cycle 8 → all outputs 0 asynchronously, no done. After release, 65535/255 → q=257, r=0.
- Random sweep of 1000 operand pairs including divisor=1, divisor>dividend, dividend=0 → q*divisor+r==dividend and r<divisor every time.
